fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter D, default 12, program-counter and branch-target width.
REQ-002 Parameter CW, default 16, cycle-counter width.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Start  input  1  level; high holds block in IDLE with PC cleared; first low cycle launches program.
REQ-006 Stall  input  1  hold PC this cycle.
REQ-007 Halt  input  1  decoded halt instruction; ends program.
REQ-008 BranchAbs  input  1  unconditional absolute jump to Target.
REQ-009 BranchRelEn  input  1  relative branch request.
REQ-010 Cond  input  1  branch condition (ALU flag); qualifies BranchRelEn.
REQ-011 Target  input  D  jump address (absolute) or two's-complement offset (relative), from branch-target LUT.
REQ-012 ProgCtr  output  D  registered instruction address.
REQ-013 FetchValid  output  1  registered; high when ProgCtr addresses an instruction to execute.
REQ-014 Done  output  1  registered; program halted.
REQ-015 CycleCnt  output  CW  registered count of RUN cycles.

Function
REQ-016 FSM states IDLE, RUN, DONE; state, ProgCtr, Done and CycleCnt are registers.
REQ-017 Start high in any state: next state IDLE, ProgCtr<=0, CycleCnt<=0, Done<=0; overrides every other input.
REQ-018 IDLE with Start low: next state RUN, ProgCtr stays 0, CycleCnt stays 0.
REQ-019 FetchValid is 1 exactly when state==RUN; 0 in IDLE and DONE.
REQ-020 RUN next-PC priority, highest first: Halt, Stall, BranchAbs, (BranchRelEn & Cond), sequential.
REQ-021 Halt in RUN: next state DONE, ProgCtr held, Done<=1 next cycle; Stall/branch inputs ignored.
REQ-022 Stall in RUN (no Halt): ProgCtr held; CycleCnt still increments.
REQ-023 BranchAbs: ProgCtr<=Target, interpreted unsigned.
REQ-024 BranchRelEn & Cond, BranchAbs low: ProgCtr<=(ProgCtr+Target) mod 2^D, Target sign-extended, carry discarded.
REQ-025 BranchRelEn with Cond low: treated as sequential.
REQ-026 Sequential: ProgCtr<=ProgCtr+1 mod 2^D (2^D-1 wraps to 0).
REQ-027 CycleCnt increments by 1 every RUN cycle and saturates at 2^CW-1.
REQ-028 DONE: all outputs held (Done=1, ProgCtr, CycleCnt frozen) until Start high.
REQ-029 Branch/Halt/Stall inputs are ignored in IDLE and DONE.
REQ-030 Next-PC path purely combinational from registered ProgCtr; one-cycle latency from inputs to ProgCtr.

Reset
REQ-031 Reset low asynchronously forces state IDLE, ProgCtr=0, FetchValid=0, Done=0, CycleCnt=0.
REQ-032 Reset asserted mid-RUN discards the pending update; after release, block stays IDLE until a Start-low cycle.
REQ-033 Reset release is consumed synchronously; the first edge after release applies REQ-017/018 normally.

Structure
REQ-034 Shared package holds state enum (IDLE, RUN, DONE), default PC width 12 and CW 16.
REQ-035 No sub-module; the branch-target LUT is instantiated by the parent and drives Target.

Verification
REQ-036 Reset, Start high 2 cycles then low -> RUN; ProgCtr 0,1,2,3 on consecutive cycles; FetchValid=1; CycleCnt 0,1,2,3.
REQ-037 ProgCtr=40, BranchRelEn=1, Cond=1, Target=-26 -> ProgCtr=14 next cycle; repeat with Cond=0 -> 41.
REQ-038 ProgCtr=0xFFE, relative Target=8 -> 0x006; sequential from 0xFFF -> 0x000.
REQ-039 ProgCtr=10, BranchAbs=1 and BranchRelEn=1, Cond=1, Target=184 -> ProgCtr=184 (absolute wins); Stall=1 same cycle -> ProgCtr stays 10.
REQ-040 Halt at ProgCtr=57 -> Done=1, FetchValid=0, ProgCtr=57 held 5 cycles; Start pulse -> IDLE, ProgCtr=0, Done=0.
REQ-041 Reset low asynchronously at ProgCtr=100 mid-cycle -> outputs zero immediately; CW=4 run of 20 cycles -> CycleCnt saturates at 15.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default widths for the instruction-fetch controller.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int PC_W  = 12;
    localparam int CNT_W = 16;

endpackage

// File: rtl/fetch_ctrl.sv
// Purpose: program-counter sequencer with halt, stall, absolute and relative branches.
// Latency: one cycle from control inputs to prog_ctr; all outputs registered.
// Backpressure: stall holds prog_ctr while the RUN cycle counter keeps counting.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int D  = PC_W,
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    input  logic          halt,
    input  logic          branch_abs,
    input  logic          branch_rel_en,
    input  logic          cond,
    input  logic [D-1:0]  target,
    output logic [D-1:0]  prog_ctr,
    output logic          fetch_valid,
    output logic          done,
    output logic [CW-1:0] cycle_cnt
);

    state_t        state;
    logic [D-1:0]  next_pc;
    logic [CW-1:0] cnt_inc;

    // Relative offset is D bits wide, so the modular sum already equals a sign-extended add.
    always_comb begin
        next_pc = prog_ctr;
        if (halt || stall) begin
            next_pc = prog_ctr;
        end else if (branch_abs) begin
            next_pc = target;
        end else if (branch_rel_en && cond) begin
            next_pc = prog_ctr + target;
        end else begin
            next_pc = prog_ctr + D'(1);
        end
    end

    assign cnt_inc = (cycle_cnt == {CW{1'b1}}) ? cycle_cnt : cycle_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            prog_ctr    <= '0;
            fetch_valid <= 1'b0;
            done        <= 1'b0;
            cycle_cnt   <= '0;
        end else if (start) begin
            state       <= ST_IDLE;
            prog_ctr    <= '0;
            fetch_valid <= 1'b0;
            done        <= 1'b0;
            cycle_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state       <= ST_RUN;
                    fetch_valid <= 1'b1;
                end
                ST_RUN: begin
                    cycle_cnt <= cnt_inc;
                    prog_ctr  <= next_pc;
                    if (halt) begin
                        state       <= ST_DONE;
                        fetch_valid <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_DONE;
                end
                default: begin
                    state       <= ST_IDLE;
                    fetch_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequencing, branches, halt, reset and counter saturation.
module tb_fetch_ctrl;
    import fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, stall, halt, branch_abs, branch_rel_en, cond;
    logic [11:0] target;
    logic [11:0] prog_ctr;
    logic        fetch_valid, done;
    logic [15:0] cycle_cnt;

    logic        start_s;
    logic [11:0] prog_ctr_s;
    logic        fetch_valid_s, done_s;
    logic [3:0]  cycle_cnt_s;
    logic        zero_b = 1'b0;
    logic [11:0] zero_t = 12'd0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.D(12), .CW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .halt(halt),
        .branch_abs(branch_abs), .branch_rel_en(branch_rel_en), .cond(cond),
        .target(target), .prog_ctr(prog_ctr), .fetch_valid(fetch_valid),
        .done(done), .cycle_cnt(cycle_cnt)
    );

    fetch_ctrl #(.D(12), .CW(4)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .stall(zero_b), .halt(zero_b),
        .branch_abs(zero_b), .branch_rel_en(zero_b), .cond(zero_b),
        .target(zero_t), .prog_ctr(prog_ctr_s), .fetch_valid(fetch_valid_s),
        .done(done_s), .cycle_cnt(cycle_cnt_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; halt = 0; branch_abs = 0; branch_rel_en = 0; cond = 0; target = '0;
    endtask

    task automatic jump_abs(input logic [11:0] t);
        idle_inputs();
        branch_abs = 1; target = t;
        step();
        idle_inputs();
    endtask

    initial begin
        rst_n = 0; start = 1; start_s = 1;
        idle_inputs();
        #3;
        check("rst_pc",    prog_ctr, 0);
        check("rst_fv",    fetch_valid, 0);
        check("rst_done",  done, 0);
        check("rst_cnt",   cycle_cnt, 0);
        #10 rst_n = 1;

        step(); step();
        check("idle_fv", fetch_valid, 0);
        start = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("seq_pc%0d", i),  prog_ctr, i);
            check($sformatf("seq_cnt%0d", i), cycle_cnt, i);
            check($sformatf("seq_fv%0d", i),  fetch_valid, 1);
        end

        jump_abs(12'd40);
        check("abs40", prog_ctr, 40);
        branch_rel_en = 1; cond = 1; target = 12'hFE6;
        step(); idle_inputs();
        check("rel_neg", prog_ctr, 14);
        jump_abs(12'd40);
        branch_rel_en = 1; cond = 0; target = 12'hFE6;
        step(); idle_inputs();
        check("rel_nocond", prog_ctr, 41);

        jump_abs(12'hFFE);
        branch_rel_en = 1; cond = 1; target = 12'd8;
        step(); idle_inputs();
        check("rel_wrap", prog_ctr, 12'h006);
        jump_abs(12'hFFF);
        step();
        check("seq_wrap", prog_ctr, 0);

        jump_abs(12'd10);
        branch_abs = 1; branch_rel_en = 1; cond = 1; target = 12'd184;
        step(); idle_inputs();
        check("abs_wins", prog_ctr, 184);
        jump_abs(12'd10);
        branch_abs = 1; branch_rel_en = 1; cond = 1; target = 12'd184; stall = 1;
        step(); idle_inputs();
        check("stall_wins", prog_ctr, 10);
        check("stall_cnt",  cycle_cnt, 15);

        jump_abs(12'd57);
        halt = 1; branch_abs = 1; target = 12'd300;
        step();
        check("halt_done", done, 1);
        check("halt_fv",   fetch_valid, 0);
        check("halt_pc",   prog_ctr, 57);
        check("halt_cnt",  cycle_cnt, 17);
        halt = 0; branch_abs = 1; branch_rel_en = 1; cond = 1; target = 12'd5;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("done_pc%0d", i),   prog_ctr, 57);
            check($sformatf("done_flag%0d", i), done, 1);
            check($sformatf("done_cnt%0d", i),  cycle_cnt, 17);
        end
        idle_inputs();
        start = 1;
        step();
        check("restart_pc",   prog_ctr, 0);
        check("restart_done", done, 0);
        check("restart_cnt",  cycle_cnt, 0);
        check("restart_fv",   fetch_valid, 0);

        start = 0;
        step();
        check("rerun_fv", fetch_valid, 1);
        jump_abs(12'd100);
        check("pre_rst_pc", prog_ctr, 100);
        #3 rst_n = 0;
        #1;
        check("arst_pc",   prog_ctr, 0);
        check("arst_fv",   fetch_valid, 0);
        check("arst_cnt",  cycle_cnt, 0);
        step();
        rst_n = 1;
        step();
        check("post_rst_pc", prog_ctr, 0);
        check("post_rst_fv", fetch_valid, 1);

        start_s = 0;
        step();
        check("sat_start", cycle_cnt_s, 0);
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) check("sat_14", cycle_cnt_s, 14);
        end
        check("sat_15", cycle_cnt_s, 15);
        check("sat_pc", prog_ctr_s, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
